aes_word_loader: RTL and testbench

- Upstream/downstream wrapper around the AES-256 round datapath and its control FSM.
- Accepts the 256-bit key and 128-bit plaintext as a 32-bit valid/ready word stream, then presents them in parallel to the core.
- Issues a one-cycle start pulse and waits a fixed core latency, then captures the 128-bit ciphertext.
- Streams the ciphertext back out as four 32-bit words with valid/ready.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_word_loader_out_serializer.sv | 48 ++++
 rtl/aes_word_loader.sv | 130 +++++++++++++
 tb/tb_aes_word_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared bus widths and loader state encodings for the AES word loader.
package aes_pkg;

  localparam int unsigned AES_WORD_W    = 32;
  localparam int unsigned AES_KEY_W     = 256;
  localparam int unsigned AES_BLK_W     = 128;
  localparam int unsigned AES_BLK_WORDS = AES_BLK_W / AES_WORD_W;

  // Loader states; the encodings match the legacy control decode.
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;
  localparam logic [1:0] DRAIN = 2'b11;

endpackage

// File: rtl/aes_word_loader_out_serializer.sv
// out_serializer: holds one 128-bit ciphertext block and streams it out as
// 32-bit words, MSB word first, with valid/ready and a last flag.
module out_serializer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [AES_BLK_W-1:0]  blk,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] out_data,
  output logic                  out_last,
  output logic                  done
);

  localparam int unsigned       IDX_W    = $clog2(AES_BLK_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(AES_BLK_WORDS - 1);

  // Element 0 sits at the MSB end, so blk_q[0] is ciphertext bits [127:96].
  logic [0:AES_BLK_WORDS-1][AES_WORD_W-1:0] blk_q;
  logic [IDX_W-1:0]                         idx;
  logic                                     fire;

  assign fire     = out_valid && out_ready;
  assign out_last = out_valid && (idx == LAST_IDX);
  assign done     = fire && out_last;
  assign out_data = out_valid ? blk_q[idx] : '0;

  // Capture the block, then advance one word per accepted handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      blk_q     <= blk;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (fire) begin
      idx <= idx + 1'b1;
      if (idx == LAST_IDX) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_word_loader.sv
// aes_word_loader: collects key and plaintext words from a 32-bit stream,
// presents them in parallel to the AES-256 core, pulses start, waits the fixed
// core latency, captures the ciphertext and streams it back out.
// Optional: define AES_KEY_REUSE_EN to add in_keep_key, which lets a block
// skip its key words and reuse the previously loaded key.
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 15,
  parameter int unsigned KEY_WORDS    = 8,
  parameter int unsigned DATA_WORDS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] in_data,
`ifdef AES_KEY_REUSE_EN
  input  logic                  in_keep_key,
`endif
  output logic                  start,
  output logic [AES_KEY_W-1:0]  key,
  output logic [AES_BLK_W-1:0]  data_in,
  input  logic [AES_BLK_W-1:0]  data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned      LAT_W     = $clog2(CORE_LATENCY + 1);
  localparam int unsigned      KI_W      = $clog2(KEY_WORDS);
  localparam int unsigned      DI_W      = $clog2(DATA_WORDS);
  localparam logic [3:0]       LAST_SLOT = 4'(KEY_WORDS + DATA_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(CORE_LATENCY - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       word_cnt;
  logic [3:0]       word_slot;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             capture;
  logic             drain_done;
  logic [KI_W-1:0]  key_idx;
  logic [DI_W-1:0]  data_idx;

  // Word 0 of each group lands at the MSB end of key / data_in.
  logic [0:KEY_WORDS-1][AES_WORD_W-1:0]  key_w;
  logic [0:DATA_WORDS-1][AES_WORD_W-1:0] data_w;

  assign accept   = in_valid && in_ready;
  assign capture  = (state == WAIT) && (lat_cnt == '0);
  assign start    = (state == START);
  assign key      = key_w;
  assign data_in  = data_w;

  // A keep-key block treats its first word as data word 0, so the slot jumps
  // straight past the key words and the normal last-slot test still applies.
`ifdef AES_KEY_REUSE_EN
  assign word_slot = ((word_cnt == '0) && in_keep_key) ? 4'(KEY_WORDS) : word_cnt;
`else
  assign word_slot = word_cnt;
`endif

  assign key_idx  = KI_W'(word_slot);
  assign data_idx = DI_W'(word_slot - 4'(KEY_WORDS));

  // Next-state decode for the load / start / wait / drain sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && (word_slot == LAST_SLOT)) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // State, registered in_ready, word counter and core latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      in_ready <= 1'b0;
      word_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == LOAD);
      if (accept) begin
        word_cnt <= word_slot + 4'd1;
      end else if (drain_done) begin
        word_cnt <= '0;
      end
      if (state == START) begin
        lat_cnt <= LAT_INIT;
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  // Steer each accepted word into its key or plaintext slot; only LOAD accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_w  <= '0;
      data_w <= '0;
    end else if (accept) begin
      if (word_slot < 4'(KEY_WORDS)) begin
        key_w[key_idx] <= in_data;
      end else begin
        data_w[data_idx] <= in_data;
      end
    end
  end

  out_serializer u_out_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .blk       (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (drain_done)
  );

endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: randomized stimulus against a transaction-level model of
// the loader (word lists in, one start per block, ciphertext words out), plus
// literal FIPS-197 C.3 expectations, reset-during-wait and back-to-back timing.
module tb_aes_word_loader;

  localparam int unsigned LAT    = 15;
  localparam int          PERIOD = 12 + 1 + LAT + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
`ifdef AES_KEY_REUSE_EN
  logic         in_keep_key = 1'b0;
`endif
  logic         start;
  logic [255:0] key;
  logic [127:0] data_in;
  logic [127:0] data_out = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
  logic         keep_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  aes_word_loader #(
    .CORE_LATENCY (LAT),
    .KEY_WORDS    (8),
    .DATA_WORDS   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef AES_KEY_REUSE_EN
    .in_keep_key (in_keep_key),
`endif
    .start     (start),
    .key       (key),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

`ifdef AES_KEY_REUSE_EN
  assign keep_in = in_keep_key;
`else
  assign keep_in = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  bit           loading;
  logic [31:0]  acc_words[$];
  bit           blk_keep;
  logic [255:0] m_key;
  logic [127:0] m_data;
  logic [127:0] m_cipher;
  int           exp_start  = -1;
  int           core_start = -1;
  logic [31:0]  outq[$];
  bit           use_fips   = 1'b0;
  bit           stall_mode = 1'b0;
  int           n_starts   = 0;
  int           start_log[$];
  int           last_acc   = -1;
  int           blocks_done = 0;
  logic [31:0]  got_words[$];
  bit           got_last[$];

  function automatic logic [127:0] stub_cipher(input logic [255:0] k, input logic [127:0] d);
    return k[255:128] ^ k[127:0] ^ d ^ 128'h5a5a_0ff0_c33c_a5a5_1234_8765_f00d_beef;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      loading    = 1'b1;
      acc_words.delete();
      outq.delete();
      m_key      = '0;
      m_data     = '0;
      exp_start  = -1;
      core_start = -1;
      data_out   = rand128();
    end else begin
      chk("in_ready", in_ready, loading);
      chk("start", start, cyc == exp_start);
      if (start) begin
        n_starts++;
        start_log.push_back(cyc);
      end
      if (cyc == exp_start) begin
        core_start = cyc;
        m_cipher   = use_fips ? FIPS_CT : stub_cipher(m_key, m_data);
      end
      if (core_start >= 0 && cyc <= core_start + LAT) begin
        chk("key_hold", key, m_key);
        chk("data_in_hold", data_in, m_data);
      end
      // input acceptance: a block is a list of words, start follows the last one
      if (loading && in_valid) begin
        if (acc_words.size() == 0) blk_keep = keep_in;
        acc_words.push_back(in_data);
        last_acc = cyc;
        if (acc_words.size() == (blk_keep ? 4 : 12)) begin
          if (!blk_keep)
            for (int i = 0; i < 8; i++) m_key[255-32*i -: 32] = acc_words[i];
          for (int i = 0; i < 4; i++) m_data[127-32*i -: 32] = acc_words[acc_words.size()-4+i];
          exp_start = cyc + 1;
          loading   = 1'b0;
          acc_words.delete();
        end
      end
      // output stream: queued ciphertext words, head held until accepted
      chk("out_valid", out_valid, outq.size() != 0);
      if (outq.size() != 0) begin
        chk("out_data", out_data, outq[0]);
        chk("out_last", out_last, outq.size() == 1);
        if (out_ready) begin
          got_words.push_back(out_data);
          got_last.push_back(out_last);
          void'(outq.pop_front());
          if (outq.size() == 0) begin
            loading    = 1'b1;
            core_start = -1;
            blocks_done++;
          end
        end
      end else begin
        chk("out_last_idle", out_last, 1'b0);
      end
      // stub core: ciphertext valid only in the cycle start+LAT
      if (core_start >= 0 && cyc == core_start + LAT) begin
        for (int j = 0; j < 4; j++) outq.push_back(m_cipher[127-32*j -: 32]);
        data_out = m_cipher;
      end else begin
        data_out = rand128();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = stall_mode ? ($urandom_range(1) == 1) : 1'b1;
  end

  // ---------------- stimulus ----------------
  logic [31:0] tx_words [12];

  task automatic send(input int n, input bit gaps, input bit keep);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    @(posedge clk); #1;
    while (i < n) begin
      if (guard++ > 2000) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
      if (gaps && $urandom_range(1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = tx_words[i];
      end
`ifdef AES_KEY_REUSE_EN
      in_keep_key = (i == 0) ? keep : ($urandom_range(1) == 1);
`else
      if (keep) chk("keep_unsupported", 1'b1, 1'b0);
`endif
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (blocks_done < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (blocks_done < target) chk("block_timeout", blocks_done, target);
  endtask

  task automatic wait_starts(input int target);
    int t = 0;
    while (n_starts < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (n_starts < target) chk("start_timeout", n_starts, target);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_start"}, start, 1'b0);
    chk({tag, "_key"}, key, '0);
    chk({tag, "_data_in"}, data_in, '0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 12; i++) tx_words[i] = $urandom();
  endtask

  initial begin
    int acc0;
    int sc;
    int t;
    int n_before;
    int b_before;
    logic [255:0] kref;

    #1 rst = 1'b0;
    #11;
    outputs_zero("reset");
    @(negedge clk); #2 rst = 1'b1;

    // FIPS-197 C.3 block, followed back-to-back by a random block
    use_fips = 1'b1;
    for (int i = 0; i < 8; i++)
      tx_words[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    tx_words[8]  = 32'h00112233;
    tx_words[9]  = 32'h44556677;
    tx_words[10] = 32'h8899aabb;
    tx_words[11] = 32'hccddeeff;
    send(12, 1'b0, 1'b0);
    acc0 = last_acc;
    wait_starts(1);
    chk("fips_key", key, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("fips_data_in", data_in, 128'h00112233445566778899aabbccddeeff);
    if (start_log.size() > 0) chk("fips_start_delay", start_log[0] - acc0, 1);
    rand_words();
    send(12, 1'b0, 1'b0);
    use_fips = 1'b0;
    wait_done(2);
    if (got_words.size() >= 4) begin
      chk("fips_ct0", got_words[0], 32'h8ea2b7ca);
      chk("fips_ct1", got_words[1], 32'h516745bf);
      chk("fips_ct2", got_words[2], 32'heafc4990);
      chk("fips_ct3", got_words[3], 32'h4b496089);
      for (int i = 0; i < 4; i++) chk("fips_last", got_last[i], i == 3);
    end else begin
      chk("fips_word_count", got_words.size(), 4);
    end
    if (start_log.size() >= 2) chk("b2b_period", start_log[1] - start_log[0], PERIOD);
    else chk("b2b_starts", start_log.size(), 2);

    // random input gaps and output stalls
    stall_mode = 1'b1;
    for (int b = 0; b < 6; b++) begin
      rand_words();
      send(12, 1'b1, 1'b0);
      wait_done(3 + b);
    end

    // reset while the latency counter is at 5
    stall_mode = 1'b0;
    rand_words();
    send(12, 1'b0, 1'b0);
    wait_starts(n_starts + 1);
    sc = start_log[start_log.size()-1];
    t = 0;
    while (cyc < sc + 10 && t < 100) begin
      @(negedge clk);
      t++;
    end
    #1 rst = 1'b0;
    #1 outputs_zero("midwait_reset");
    @(negedge clk); #2 rst = 1'b1;
    n_before = n_starts;
    b_before = blocks_done;
    rand_words();
    send(12, 1'b1, 1'b0);
    wait_done(b_before + 1);
    chk("post_reset_starts", n_starts, n_before + 1);

`ifdef AES_KEY_REUSE_EN
    // key reuse: a 4-word block keeps the previous key
    rand_words();
    for (int i = 0; i < 8; i++) kref[255-32*i -: 32] = tx_words[i];
    send(12, 1'b1, 1'b0);
    wait_done(blocks_done + 1);
    b_before = blocks_done;
    n_before = n_starts;
    rand_words();
    send(4, 1'b1, 1'b1);
    wait_starts(n_before + 1);
    chk("reuse_key", key, kref);
    chk("reuse_data_in", data_in, {tx_words[0], tx_words[1], tx_words[2], tx_words[3]});
    wait_done(b_before + 1);
`else
    kref = '0;
    chk("default_key_nonzero", key != kref, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
